draw_source_scheduler: RTL
==========================

Name: draw_source_scheduler

Overview:
- Per-frame sequencer for the shared draw-manager write bus. Drives write_source_sel and write_awaited to grant the bus to each enabled draw source in ascending ID order.
- Observes each source's write_active burst, recovers from stalled sources by timeout, then requests a framebuffer swap.
- Sits between the frame timing logic, the draw sources (starfield, sprites, HUD) and the framebuffer manager.

Parameters:
- NUM_SOURCES, 4: number of draw sources; IDs are 0..NUM_SOURCES-1.
- SOURCE_SEL_ADDRW, 3: width of write_source_sel.
- IDLE_SEL, 7: select value driven when no source owns the bus; must be >= NUM_SOURCES.
- TIMEOUT_CYCLES, 4096: max cycles per grant, counted from AWAIT entry to end of DRAIN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- frame  in  1  one-cycle pulse at frame start.
- source_enable  in  NUM_SOURCES  per-source enable mask.
- write_active  in  1  shared tri-state bus line from the selected source. Anything other than 1 (including z/x) is treated as 0.
- write_source_sel  out  SOURCE_SEL_ADDRW  current bus owner ID.
- write_awaited  out  1  grant strobe to the selected source.
- fb_swap_req  out  1  framebuffer swap request, level.
- fb_swap_ack  in  1  swap completed, one-cycle pulse.
- busy  out  1  high whenever the state is not IDLE.
- frame_done  out  1  one-cycle pulse when the swap is acknowledged.
- timeout_flags  out  NUM_SOURCES  sticky per source; set when that source's grant times out.
- overrun_count  out  8  saturating count of frames that arrived while busy.

Behaviour:
- Reset values (async on rst=1): state IDLE, write_source_sel=IDLE_SEL, write_awaited=0, fb_swap_req=0, busy=0, frame_done=0, timeout_flags=0, overrun_count=0, pending=0, timer=0.
- All outputs are registered.
- State IDLE:
  - Entered on frame=1 or pending=1: latch mask <= source_enable, clear pending, go to SELECT.
  - Otherwise stay in IDLE.
- State SELECT (1 cycle):
  - Find the lowest index i with mask[i]=1 and i greater than the last served ID (the first search after IDLE starts from 0).
  - If found: write_source_sel<=i, write_awaited<=1, timer<=0, go to AWAIT.
  - If none: write_source_sel<=IDLE_SEL, go to SWAP.
- State AWAIT: write_awaited held at 1, timer increments.
  - write_active=1: write_awaited<=0, go to DRAIN.
  - Else if timer reaches TIMEOUT_CYCLES-1: set timeout_flags[i], write_awaited<=0, go to SELECT.
- State DRAIN: timer keeps incrementing; write_source_sel stays i.
  - write_active=0: go to SELECT.
  - Else if timer reaches TIMEOUT_CYCLES-1: set timeout_flags[i], go to SELECT.
- Grant latency: sel and awaited are visible 1 cycle after SELECT is entered. The source's write_active must be seen high before write_awaited drops.
- Bus idle gap: after write_active falls, the next source's sel changes after 1 cycle (SELECT).
- State SWAP: write_source_sel=IDLE_SEL, fb_swap_req=1 (held).
  - On fb_swap_ack=1: fb_swap_req<=0, frame_done<=1 for 1 cycle, go to IDLE.
  - No timeout in SWAP.
- Frame overrun: frame=1 in any state other than IDLE sets pending=1 and increments overrun_count (saturates at 255). Multiple overruns collapse to a single pending start.
- frame=1 in the same cycle that SWAP exits to IDLE counts as an overrun, sets pending, and the next frame starts 1 cycle later.
- Mask changes mid-frame are ignored; only the latched mask is used.
- All-zero mask: IDLE -> SELECT -> SWAP; no grant is issued.
- A timed-out source is skipped for the rest of that frame only. Its timeout_flag stays set until rst.
- write_active=1 while in IDLE or SWAP is ignored.

Test Plan:
- Enable mask 4'b1111, model sources that raise write_active 3 cycles after awaited and hold it 50 cycles -> grants go in order 0,1,2,3; each AWAIT->DRAIN transition happens on the write_active edge; fb_swap_req rises after source 3 drops; ack -> frame_done pulse; timeout_flags=0.
- Mask 4'b1010 -> only IDs 1 then 3 are selected; sel=IDLE_SEL in IDLE and SWAP.
- Source 2 never asserts write_active, TIMEOUT_CYCLES=16 -> awaited drops after 16 cycles, timeout_flags=4'b0100, source 3 is then served normally.
- Source 1 holds write_active forever -> DRAIN times out at 16 cycles and scheduling proceeds to source 3.
- Two frame pulses during a busy frame -> overrun_count=2, pending causes exactly one restart right after frame_done; 300 overruns -> count saturates at 255.
- Assert rst mid-DRAIN -> all outputs return to reset values immediately (asynchronously); the next frame starts from ID 0.

Source files
------------

// File: rtl/draw_source_scheduler.sv
`default_nettype none
// draw_source_scheduler: per-frame sequencer that grants the shared draw write bus to each
// enabled source in ascending ID order, recovers stalled grants by timeout, then requests a swap.
module draw_source_scheduler #(
    parameter int NUM_SOURCES      = 4,
    parameter int SOURCE_SEL_ADDRW = 3,
    parameter int IDLE_SEL         = 7,
    parameter int TIMEOUT_CYCLES   = 4096
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        frame,
    input  logic [NUM_SOURCES-1:0]      source_enable,
    input  logic                        write_active,
    output logic [SOURCE_SEL_ADDRW-1:0] write_source_sel,
    output logic                        write_awaited,
    output logic                        fb_swap_req,
    input  logic                        fb_swap_ack,
    output logic                        busy,
    output logic                        frame_done,
    output logic [NUM_SOURCES-1:0]      timeout_flags,
    output logic [7:0]                  overrun_count
);
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SOURCE_SEL_ADDRW-1:0] SEL_IDLE   = SOURCE_SEL_ADDRW'(IDLE_SEL);
    localparam logic [TIMER_W-1:0]          TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_AWAIT  = 3'd2,
        S_DRAIN  = 3'd3,
        S_SWAP   = 3'd4
    } state_t;

    state_t                      state;
    logic [NUM_SOURCES-1:0]      mask;
    logic [SOURCE_SEL_ADDRW-1:0] next_id;
    logic [TIMER_W-1:0]          timer;
    logic                        pending;

    logic                        found;
    logic [SOURCE_SEL_ADDRW-1:0] pick;
    logic [NUM_SOURCES-1:0]      owner_bit;
    logic                        active;
    logic                        expired;

    // A floating or unknown bus line must never count as an active write.
    assign active  = (write_active == 1'b1);
    assign expired = (timer >= TIMER_LAST);

    // Lowest enabled ID at or above next_id; descending scan lets the lowest match win.
    always_comb begin
        found     = 1'b0;
        pick      = SEL_IDLE;
        owner_bit = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (mask[i] && (SOURCE_SEL_ADDRW'(i) >= next_id)) begin
                found = 1'b1;
                pick  = SOURCE_SEL_ADDRW'(i);
            end
        end
        for (int i = 0; i < NUM_SOURCES; i++) begin
            owner_bit[i] = (write_source_sel == SOURCE_SEL_ADDRW'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            mask             <= '0;
            next_id          <= '0;
            timer            <= '0;
            pending          <= 1'b0;
            write_source_sel <= SEL_IDLE;
            write_awaited    <= 1'b0;
            fb_swap_req      <= 1'b0;
            busy             <= 1'b0;
            frame_done       <= 1'b0;
            timeout_flags    <= '0;
            overrun_count    <= '0;
        end else begin
            frame_done <= 1'b0;
            if (frame && (state != S_IDLE)) begin
                pending <= 1'b1;
                if (overrun_count != 8'hFF) begin
                    overrun_count <= overrun_count + 8'd1;
                end
            end
            case (state)
                S_IDLE: begin
                    if (frame || pending) begin
                        mask    <= source_enable;
                        pending <= 1'b0;
                        next_id <= '0;
                        busy    <= 1'b1;
                        state   <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (found) begin
                        write_source_sel <= pick;
                        write_awaited    <= 1'b1;
                        timer            <= '0;
                        next_id          <= pick + SOURCE_SEL_ADDRW'(1);
                        state            <= S_AWAIT;
                    end else begin
                        write_source_sel <= SEL_IDLE;
                        fb_swap_req      <= 1'b1;
                        state            <= S_SWAP;
                    end
                end
                S_AWAIT: begin
                    timer <= timer + TIMER_W'(1);
                    if (active) begin
                        write_awaited <= 1'b0;
                        state         <= S_DRAIN;
                    end else if (expired) begin
                        timeout_flags <= timeout_flags | owner_bit;
                        write_awaited <= 1'b0;
                        state         <= S_SELECT;
                    end
                end
                S_DRAIN: begin
                    timer <= timer + TIMER_W'(1);
                    if (!active) begin
                        state <= S_SELECT;
                    end else if (expired) begin
                        timeout_flags <= timeout_flags | owner_bit;
                        state         <= S_SELECT;
                    end
                end
                S_SWAP: begin
                    if (fb_swap_ack) begin
                        fb_swap_req <= 1'b0;
                        frame_done  <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire
